// File: rtl/collision_pkg.sv
// Shared types and constants for the collision engine.
//   state_t            : scan FSM states
//   *_DEF              : default configuration (arena bounds, sizes)
//   SHIFT/HALF/HP_W/IDX_W : derived constants for the default configuration
//   idx_width/cnt_width   : width helpers that never return zero
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    localparam int unsigned N_ZOMBIES_DEF     = 10;
    localparam int unsigned COORD_W_DEF       = 10;
    localparam int unsigned SPRITE_DEF        = 32;
    localparam int unsigned ZOMBIE_HP_DEF     = 3;
    localparam int unsigned INVULN_FRAMES_DEF = 60;
    localparam int unsigned X_MIN_DEF         = 32;
    localparam int unsigned X_MAX_DEF         = 607;
    localparam int unsigned Y_MIN_DEF         = 64;
    localparam int unsigned Y_MAX_DEF         = 447;
    localparam int unsigned BULLET_SIZE_DEF   = 4;
    localparam int unsigned GRID_ROWS_DEF     = 15;
    localparam int unsigned GRID_COLS_DEF     = 20;

    localparam int unsigned SHIFT = $clog2(SPRITE_DEF);
    localparam int unsigned HALF  = SPRITE_DEF / 2 - 1;
    localparam int unsigned HP_W  = $clog2(ZOMBIE_HP_DEF + 1);
    localparam int unsigned IDX_W = $clog2(N_ZOMBIES_DEF);

    // Index width for n slots, at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..max, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational geometry tests for one zombie sprite.
//   box_x/box_y   in : sprite top-left corner
//   pt_x/pt_y     in : point tested for containment (bullet)
//   near_x/near_y in : corner tested for proximity (shooter)
//   point_in_c    out: point lies inside the SPRITE x SPRITE box
//   near_c        out: both corner distances are within SPRITE/2-1
module box_overlap
    import collision_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned SPRITE  = SPRITE_DEF
) (
    input  logic [COORD_W-1:0] box_x,
    input  logic [COORD_W-1:0] box_y,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    input  logic [COORD_W-1:0] near_x,
    input  logic [COORD_W-1:0] near_y,
    output logic               point_in_c,
    output logic               near_c
);

    // One extra bit so box_x + SPRITE - 1 and signed differences never wrap.
    localparam int unsigned EW     = COORD_W + 1;
    localparam int unsigned HALF_L = SPRITE / 2 - 1;

    logic [EW-1:0]        bx_e, by_e, bx_hi, by_hi, px_e, py_e;
    logic signed [EW-1:0] dx, dy;
    logic [EW-1:0]        adx, ady;

    always_comb begin
        bx_e  = {1'b0, box_x};
        by_e  = {1'b0, box_y};
        px_e  = {1'b0, pt_x};
        py_e  = {1'b0, pt_y};
        bx_hi = bx_e + EW'(SPRITE - 1);
        by_hi = by_e + EW'(SPRITE - 1);
        point_in_c = (px_e >= bx_e) && (px_e <= bx_hi) &&
                     (py_e >= by_e) && (py_e <= by_hi);

        dx  = $signed(bx_e) - $signed({1'b0, near_x});
        dy  = $signed(by_e) - $signed({1'b0, near_y});
        adx = dx[EW-1] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[EW-1] ? $unsigned(-dy) : $unsigned(dy);
        near_c = (adx <= EW'(HALF_L)) && (ady <= EW'(HALF_L));
    end

endmodule

// File: rtl/collision_engine.sv
// Per-frame collision scanner: visits one zombie slot per cycle, tracks
// per-slot hit points, shooter invulnerability and a saturating kill count.
//   Clk, Reset_n            : clock, async active-low reset
//   frame_tick              : starts a scan (dropped and flagged when busy)
//   zombie_*, bullet_*,
//   shooter_*, barrier      : sprite positions and barrier map
//   busy                    : scan or resolve in progress
//   remove_bullet, zombie_dead, shooter_take_damage : one-cycle result pulses
//   shooter_invuln, zombie_hp, kill_count, tick_overrun : status
module collision_engine
    import collision_pkg::*;
#(
    parameter int unsigned N_ZOMBIES     = N_ZOMBIES_DEF,
    parameter int unsigned COORD_W       = COORD_W_DEF,
    parameter int unsigned SPRITE        = SPRITE_DEF,
    parameter int unsigned ZOMBIE_HP     = ZOMBIE_HP_DEF,
    parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
    parameter int unsigned X_MIN         = X_MIN_DEF,
    parameter int unsigned X_MAX         = X_MAX_DEF,
    parameter int unsigned Y_MIN         = Y_MIN_DEF,
    parameter int unsigned Y_MAX         = Y_MAX_DEF,
    parameter int unsigned BULLET_SIZE   = BULLET_SIZE_DEF,
    parameter int unsigned GRID_ROWS     = GRID_ROWS_DEF,
    parameter int unsigned GRID_COLS     = GRID_COLS_DEF
) (
    input  logic                                        Clk,
    input  logic                                        Reset_n,
    input  logic                                        frame_tick,
    input  logic [N_ZOMBIES*COORD_W-1:0]                zombie_x,
    input  logic [N_ZOMBIES*COORD_W-1:0]                zombie_y,
    input  logic [N_ZOMBIES-1:0]                        zombie_alive,
    input  logic [N_ZOMBIES-1:0]                        zombie_spawn,
    input  logic [COORD_W-1:0]                          bullet_x,
    input  logic [COORD_W-1:0]                          bullet_y,
    input  logic                                        bullet_active,
    input  logic [COORD_W-1:0]                          shooter_x,
    input  logic [COORD_W-1:0]                          shooter_y,
    input  logic [GRID_ROWS*GRID_COLS*2-1:0]            barrier,
    output logic                                        busy,
    output logic                                        remove_bullet,
    output logic [N_ZOMBIES-1:0]                        zombie_dead,
    output logic                                        shooter_take_damage,
    output logic                                        shooter_invuln,
    output logic [N_ZOMBIES*$clog2(ZOMBIE_HP+1)-1:0]    zombie_hp,
    output logic [15:0]                                 kill_count,
    output logic                                        tick_overrun
);

    localparam int unsigned EW  = COORD_W + 1;
    localparam int unsigned SH  = $clog2(SPRITE);
    localparam int unsigned HPW = $clog2(ZOMBIE_HP + 1);
    localparam int unsigned IW  = idx_width(N_ZOMBIES);
    localparam int unsigned CW  = cnt_width(INVULN_FRAMES);

    state_t                       state, state_nxt;
    logic [IW-1:0]                idx, idx_nxt;
    logic [COORD_W-1:0]           bx_q, by_q, sx_q, sy_q;
    logic [COORD_W-1:0]           bx_nxt, by_nxt, sx_nxt, sy_nxt;
    logic                         bact_q, bact_nxt;
    logic                         hit_q, hit_nxt, ov_q, ov_nxt;
    logic [IW-1:0]                hit_idx_q, hit_idx_nxt;
    logic [CW-1:0]                inv_cnt, inv_nxt;
    logic [N_ZOMBIES-1:0][HPW-1:0] hp_q, hp_nxt;
    logic [15:0]                  kill_nxt;
    logic                         overrun_nxt, busy_nxt, rb_nxt, dmg_nxt;
    logic [N_ZOMBIES-1:0]         dead_nxt;

    logic [COORD_W-1:0]           cur_x, cur_y;
    logic                         in_box, near;
    logic                         cur_hit, cur_ov, blocked, wall;
    int unsigned                  row, col;
    logic [EW-1:0]                bx_e, by_e;

    assign zombie_hp = hp_q;

    // Slot under scan, selected live from the packed position buses.
    always_comb begin
        cur_x = zombie_x[int'(idx)*COORD_W +: COORD_W];
        cur_y = zombie_y[int'(idx)*COORD_W +: COORD_W];
    end

    box_overlap #(
        .COORD_W (COORD_W),
        .SPRITE  (SPRITE)
    ) u_box (
        .box_x      (cur_x),
        .box_y      (cur_y),
        .pt_x       (bx_q),
        .pt_y       (by_q),
        .near_x     (sx_q),
        .near_y     (sy_q),
        .point_in_c (in_box),
        .near_c     (near)
    );

    // Barrier cell lookup and arena wall test on the latched bullet.
    always_comb begin
        row     = 32'(by_q >> SH);
        col     = 32'(bx_q >> SH);
        blocked = 1'b0;
        if (row < GRID_ROWS && col < GRID_COLS)
            blocked = |barrier[(row*GRID_COLS + col)*2 +: 2];
        bx_e = {1'b0, bx_q};
        by_e = {1'b0, by_q};
        wall = (by_e + EW'(BULLET_SIZE) >= EW'(Y_MAX)) ||
               (by_e <= EW'(Y_MIN + BULLET_SIZE))     ||
               (bx_e + EW'(BULLET_SIZE) >= EW'(X_MAX)) ||
               (bx_e <= EW'(X_MIN + BULLET_SIZE));
    end

    // Next-state, datapath and output pulse computation.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        bx_nxt      = bx_q;
        by_nxt      = by_q;
        bact_nxt    = bact_q;
        sx_nxt      = sx_q;
        sy_nxt      = sy_q;
        hit_nxt     = hit_q;
        hit_idx_nxt = hit_idx_q;
        ov_nxt      = ov_q;
        inv_nxt     = inv_cnt;
        hp_nxt      = hp_q;
        kill_nxt    = kill_count;
        overrun_nxt = tick_overrun;
        rb_nxt      = 1'b0;
        dmg_nxt     = 1'b0;
        dead_nxt    = '0;
        cur_hit     = 1'b0;
        cur_ov      = 1'b0;

        if (frame_tick && inv_cnt != '0)
            inv_nxt = inv_cnt - CW'(1);

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                    hit_nxt   = 1'b0;
                    ov_nxt    = 1'b0;
                    bx_nxt    = bullet_x;
                    by_nxt    = bullet_y;
                    bact_nxt  = bullet_active;
                    sx_nxt    = shooter_x;
                    sy_nxt    = shooter_y;
                end
            end
            SCAN: begin
                if (frame_tick)
                    overrun_nxt = 1'b1;
                cur_hit = zombie_alive[idx] & bact_q & in_box;
                cur_ov  = zombie_alive[idx] & near;
                if (cur_hit && !hit_q) begin
                    hit_nxt     = 1'b1;
                    hit_idx_nxt = idx;
                end
                ov_nxt = ov_q | cur_ov;
                if (idx == IW'(N_ZOMBIES - 1)) begin
                    // Resolve on this edge so the pulses are visible in RESOLVE.
                    state_nxt = RESOLVE;
                    if (hit_nxt) begin
                        rb_nxt = 1'b1;
                        if (hp_q[hit_idx_nxt] != '0) begin
                            hp_nxt[hit_idx_nxt] = hp_q[hit_idx_nxt] - HPW'(1);
                            if (hp_q[hit_idx_nxt] == HPW'(1) && !zombie_spawn[hit_idx_nxt]) begin
                                dead_nxt[hit_idx_nxt] = 1'b1;
                                if (kill_count != 16'hFFFF)
                                    kill_nxt = kill_count + 16'd1;
                            end
                        end
                    end else if (bact_q && (blocked || wall)) begin
                        rb_nxt = 1'b1;
                    end
                    if (ov_nxt && inv_cnt == '0) begin
                        dmg_nxt = 1'b1;
                        inv_nxt = CW'(INVULN_FRAMES);
                    end
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            RESOLVE: begin
                if (frame_tick)
                    overrun_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A spawn reloads HP and wins over a same-cycle decrement.
        for (int i = 0; i < int'(N_ZOMBIES); i++) begin
            if (zombie_spawn[i])
                hp_nxt[i] = HPW'(ZOMBIE_HP);
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state               <= IDLE;
            idx                 <= '0;
            bx_q                <= '0;
            by_q                <= '0;
            bact_q              <= 1'b0;
            sx_q                <= '0;
            sy_q                <= '0;
            hit_q               <= 1'b0;
            hit_idx_q           <= '0;
            ov_q                <= 1'b0;
            inv_cnt             <= '0;
            hp_q                <= '0;
            kill_count          <= '0;
            tick_overrun        <= 1'b0;
            busy                <= 1'b0;
            remove_bullet       <= 1'b0;
            zombie_dead         <= '0;
            shooter_take_damage <= 1'b0;
            shooter_invuln      <= 1'b0;
        end else begin
            state               <= state_nxt;
            idx                 <= idx_nxt;
            bx_q                <= bx_nxt;
            by_q                <= by_nxt;
            bact_q              <= bact_nxt;
            sx_q                <= sx_nxt;
            sy_q                <= sy_nxt;
            hit_q               <= hit_nxt;
            hit_idx_q           <= hit_idx_nxt;
            ov_q                <= ov_nxt;
            inv_cnt             <= inv_nxt;
            hp_q                <= hp_nxt;
            kill_count          <= kill_nxt;
            tick_overrun        <= overrun_nxt;
            busy                <= busy_nxt;
            remove_bullet       <= rb_nxt;
            zombie_dead         <= dead_nxt;
            shooter_take_damage <= dmg_nxt;
            shooter_invuln      <= (inv_nxt != '0);
        end
    end

endmodule
